// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv6_bus_pkg (bus_arbiter_pkg.sv)                                     |
// | Shared types and channel helpers for the shared-memory bus arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv6_bus_pkg;

  localparam int C_CORE_COUNT = 6;
  localparam int C_CH         = 2 * C_CORE_COUNT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Each hart owns an instruction-fetch channel and a data channel.
  function automatic int CH_IFETCH(input int h);
    return 2 * h;
  endfunction

  function automatic int CH_DATA(input int h);
    return 2 * h + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter_if                                                       |
// | Requester channels plus the external memory bus, grouped together.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface bus_arbiter_if
  import rv6_bus_pkg::*;
#(
  parameter int CH       = C_CH,
  parameter int PHY_ADDR = 48,
  parameter int DATA_W   = 16
);
  logic [CH-1:0]          m_req;
  logic [CH-1:0]          m_we;
  logic [CH-1:0]          m_last;
  logic [CH*PHY_ADDR-1:0] m_addr;
  logic [CH*DATA_W-1:0]   m_wdata;
  logic [CH-1:0]          m_gnt;
  logic [CH-1:0]          m_dv;
  logic [CH-1:0]          m_err;
  logic [DATA_W-1:0]      m_rdata;
  logic [PHY_ADDR-1:0]    addr;
  logic [DATA_W-1:0]      data_in;
  logic [DATA_W-1:0]      data_out;
  logic                   r;
  logic                   w;
  logic                   dbv;

  // Requesters and external memory side.
  modport master (
    output m_req, m_we, m_last, m_addr, m_wdata, data_in, dbv,
    input  m_gnt, m_dv, m_err, m_rdata, addr, data_out, r, w
  );

  // Arbiter side.
  modport slave (
    input  m_req, m_we, m_last, m_addr, m_wdata, data_in, dbv,
    output m_gnt, m_dv, m_err, m_rdata, addr, data_out, r, w
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first request at or after ptr.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N  = 12,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        gnt                    = '0;
        gnt[wrap_idx(ptr, k)]  = 1'b1;
        idx                    = wrap_idx(ptr, k);
        any                    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter                                                          |
// | Round-robin burst arbiter of 2*CORE_COUNT channels onto one bus.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bus_arbiter
  import rv6_bus_pkg::*;
#(
  parameter int CORE_COUNT = C_CORE_COUNT,
  parameter int PHY_ADDR   = 48,
  parameter int DATA_W     = 16,
  parameter int TIMEOUT    = 255,
  parameter int MAX_BURST  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arbiter_if.slave bus
);

  localparam int C_NCH = 2 * CORE_COUNT;
  localparam int IW    = $clog2(C_NCH);
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] C_BEAT_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] C_TO_MAX   = TW'(TIMEOUT);

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic [IW-1:0]      r_owner, w_owner_nxt;
  logic [C_NCH-1:0]   r_owner_oh, w_owner_oh_nxt;
  logic [BW-1:0]      r_beat_cnt, w_beat_nxt, w_beat_inc;
  logic [TW-1:0]      r_to_cnt, w_to_nxt, w_to_inc;
  logic [C_NCH-1:0]   w_pick_gnt;
  logic [IW-1:0]      w_pick;
  logic               w_any;
  logic               w_dv, w_err, w_busy, w_own_we;

  rr_arbiter #(.N(C_NCH)) u_rr (
    .req (bus.m_req),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick),
    .any (w_any)
  );

  assign w_beat_inc = r_beat_cnt + 1'b1;
  assign w_to_inc   = r_to_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_beat_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_owner_oh <= w_owner_oh_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_to_cnt   <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_owner_oh_nxt = r_owner_oh;
    w_beat_nxt     = r_beat_cnt;
    w_to_nxt       = r_to_cnt;
    w_dv           = 1'b0;
    w_err          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt    = BUSY;
          w_owner_nxt    = w_pick;
          w_owner_oh_nxt = w_pick_gnt;
          w_ptr_nxt      = (w_pick == IW'(C_NCH - 1)) ? '0 : w_pick + 1'b1;
          w_beat_nxt     = '0;
          w_to_nxt       = '0;
        end
      end
      BUSY: begin
        // A dropped request aborts the beat even if dbv arrives with it.
        if (!bus.m_req[r_owner]) begin
          w_state_nxt = RELEASE;
        end else if (bus.dbv) begin
          w_dv       = 1'b1;
          w_beat_nxt = w_beat_inc;
          w_to_nxt   = '0;
          if (bus.m_last[r_owner] || (w_beat_inc == C_BEAT_MAX))
            w_state_nxt = RELEASE;
        end else begin
          w_to_nxt = w_to_inc;
          if ((TIMEOUT > 0) && (w_to_inc == C_TO_MAX)) begin
            w_err       = 1'b1;
            w_state_nxt = RELEASE;
          end
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_beat_nxt  = '0;
        w_to_nxt    = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy        = (r_state == BUSY);
  assign w_own_we      = bus.m_we[r_owner];
  assign bus.m_gnt     = w_busy ? r_owner_oh : '0;
  assign bus.m_dv      = w_dv ? r_owner_oh : '0;
  assign bus.m_err     = w_err ? r_owner_oh : '0;
  assign bus.r         = w_busy & ~w_own_we;
  assign bus.w         = w_busy & w_own_we;
  assign bus.addr      = w_busy ? bus.m_addr[r_owner*PHY_ADDR +: PHY_ADDR] : '0;
  assign bus.data_out  = (w_busy & w_own_we) ? bus.m_wdata[r_owner*DATA_W +: DATA_W] : '0;
  assign bus.m_rdata   = bus.data_in;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_arbiter                                                       |
// | Directed plus randomized bench with a tenure-level reference model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bus_arbiter;
  import rv6_bus_pkg::*;

  localparam int NCH = C_CH;
  localparam int PA  = 48;
  localparam int DW  = 16;
  localparam int TO  = 4;
  localparam int MB  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.CH(NCH), .PHY_ADDR(PA), .DATA_W(DW)) bus ();

  bus_arbiter #(
    .CORE_COUNT (C_CORE_COUNT),
    .PHY_ADDR   (PA),
    .DATA_W     (DW),
    .TIMEOUT    (TO),
    .MAX_BURST  (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  bit                rq   [NCH];
  bit                we   [NCH];
  bit                last [NCH];
  int                left [NCH];
  logic [PA-1:0]     addr_a  [NCH];
  logic [DW-1:0]     wdata_a [NCH];
  logic [NCH-1:0]    exp_dv, exp_err, exp_gnt;
  bit                auto_on = 1'b0;

  // Reference: who holds the bus (-1 = nobody), idle gap left, next scan start.
  int mo_owner = -1;
  int mo_gap   = 0;
  int mo_ptr   = 0;
  int mo_beats = 0;
  int mo_waits = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mo_reset();
    mo_owner = -1; mo_gap = 0; mo_ptr = 0; mo_beats = 0; mo_waits = 0;
    exp_dv = '0; exp_err = '0; exp_gnt = '0;
  endtask

  task automatic end_tenure();
    mo_owner = -1;
    mo_gap   = 1;
  endtask

  task automatic drive(input bit dbv_i, input logic [DW-1:0] din_i);
    for (int c = 0; c < NCH; c++) begin
      bus.m_req[c]              = rq[c];
      bus.m_we[c]               = we[c];
      bus.m_last[c]             = last[c];
      bus.m_addr[c*PA +: PA]    = addr_a[c];
      bus.m_wdata[c*DW +: DW]   = wdata_a[c];
    end
    bus.dbv     = dbv_i;
    bus.data_in = din_i;
  endtask

  task automatic model_cycle();
    logic [NCH-1:0] eg, ed, ee;
    logic           er, ew;
    logic [PA-1:0]  ea;
    logic [DW-1:0]  eo;
    eg = '0; ed = '0; ee = '0; er = 1'b0; ew = 1'b0; ea = '0; eo = '0;
    if (mo_owner >= 0) begin
      int o;
      o     = mo_owner;
      eg[o] = 1'b1;
      ew    = we[o];
      er    = !we[o];
      ea    = addr_a[o];
      eo    = we[o] ? wdata_a[o] : '0;
      if (!rq[o]) begin
        end_tenure();
      end else if (bus.dbv) begin
        ed[o] = 1'b1;
        mo_beats++;
        mo_waits = 0;
        if (last[o] || mo_beats == MB) end_tenure();
      end else begin
        mo_waits++;
        if (mo_waits == TO) begin
          ee[o] = 1'b1;
          end_tenure();
        end
      end
    end else if (mo_gap > 0) begin
      mo_gap--;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (mo_ptr + k) % NCH;
        if (rq[c]) begin
          mo_owner = c;
          mo_ptr   = (c + 1) % NCH;
          mo_beats = 0;
          mo_waits = 0;
          break;
        end
      end
    end
    check("gnt",   64'(bus.m_gnt),    64'(eg));
    check("dv",    64'(bus.m_dv),     64'(ed));
    check("err",   64'(bus.m_err),    64'(ee));
    check("r",     64'(bus.r),        64'(er));
    check("w",     64'(bus.w),        64'(ew));
    check("addr",  64'(bus.addr),     64'(ea));
    check("dout",  64'(bus.data_out), 64'(eo));
    check("rdata", 64'(bus.m_rdata),  64'(bus.data_in));
    exp_dv = ed; exp_err = ee; exp_gnt = eg;
  endtask

  // Random requesters: bursts of 1..11 beats, occasional abort while granted.
  task automatic agent();
    for (int c = 0; c < NCH; c++) begin
      if (rq[c]) begin
        if (exp_dv[c]) begin
          left[c]--;
          if (left[c] == 0) rq[c] = 1'b0;
          else begin
            last[c]    = (left[c] == 1);
            addr_a[c]  = addr_a[c] + PA'(2);
            wdata_a[c] = DW'($urandom());
          end
        end else if (exp_err[c]) begin
          rq[c] = 1'b0;
        end else if (exp_gnt[c] && $urandom_range(0, 99) == 0) begin
          rq[c] = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rq[c]      = 1'b1;
        we[c]      = 1'($urandom_range(0, 1));
        left[c]    = int'($urandom_range(1, 11));
        last[c]    = (left[c] == 1);
        addr_a[c]  = PA'({$urandom(), $urandom()});
        wdata_a[c] = DW'($urandom());
      end
    end
  endtask

  task automatic step(input bit dbv_i, input logic [DW-1:0] din_i);
    drive(dbv_i, din_i);
    #1;
    model_cycle();
    if (auto_on) agent();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int c = 0; c < NCH; c++) begin
      rq[c] = 1'b0; we[c] = 1'b0; last[c] = 1'b0; left[c] = 0;
      addr_a[c] = '0; wdata_a[c] = '0;
    end
  endtask

  int pcts [3] = '{70, 30, 6};

  initial begin
    int c0, c2, c7, c9;
    c0 = CH_IFETCH(0);
    c2 = CH_IFETCH(1);
    c7 = CH_DATA(3);
    c9 = CH_DATA(4);
    clear_reqs();
    mo_reset();
    drive(1'b0, '0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt",  64'(bus.m_gnt),    64'(0));
    check("rst_r",    64'(bus.r),        64'(0));
    check("rst_w",    64'(bus.w),        64'(0));
    check("rst_addr", 64'(bus.addr),     64'(0));
    check("rst_dout", 64'(bus.data_out), 64'(0));
    check("rst_dv",   64'(bus.m_dv),     64'(0));
    check("rst_err",  64'(bus.m_err),    64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read on ch0, dbv three cycles after the request.
    rq[c0] = 1'b1; we[c0] = 1'b0; last[c0] = 1'b1; addr_a[c0] = PA'(48'h1000);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, 16'hBEEF);
    rq[c0] = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);

    // Timeout on ch2, then the same read completing exactly at the limit.
    rq[c2] = 1'b1; we[c2] = 1'b0; last[c2] = 1'b1; addr_a[c2] = PA'(48'h2222);
    repeat (5) step(1'b0, '0);
    rq[c2] = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    rq[c2] = 1'b1;
    repeat (4) step(1'b0, '0);
    step(1'b1, 16'h5A5A);
    rq[c2] = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);

    // Asynchronous reset while ch7 is writing.
    rq[c7] = 1'b1; we[c7] = 1'b1; last[c7] = 1'b0;
    addr_a[c7] = PA'(48'h7000); wdata_a[c7] = 16'h7777;
    step(1'b0, '0);
    step(1'b0, '0);
    drive(1'b0, '0);
    #1;
    check("pre_rst_w", 64'(bus.w), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 64'(bus.m_gnt), 64'(0));
    check("arst_r",   64'(bus.r),     64'(0));
    check("arst_w",   64'(bus.w),     64'(0));
    check("arst_dv",  64'(bus.m_dv),  64'(0));
    clear_reqs();
    mo_reset();
    drive(1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rq[c9] = 1'b1; we[c9] = 1'b0; last[c9] = 1'b1; addr_a[c9] = PA'(48'h9999);
    step(1'b0, '0);
    step(1'b1, 16'h1234);
    rq[c9] = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);

    // Randomized traffic with dense, medium and sparse dbv.
    auto_on = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++)
        step($urandom_range(0, 99) < pcts[ph], DW'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
